dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-lane data memory, which has 12-bit byte addresses, 32-bit data, and mode 00 word / 01 byte / 10 half.
- Port 0 is the CPU load/store unit. Port 1 is the debug/DMA loader.
- Serialises accesses and filters illegal or misaligned requests so the memory never sees mode 11. Mode 11 on a read clears the memory entry.
- Sequences the memory's clock-edge access and returns read data with a one-cycle ack.

Parameters:
- ADDR_W, 12, byte address width.
- DATA_W, 32, data width.
- PRIO_FIXED, 0. 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_mode  in  2  00 word, 01 byte, 10 half, 11 illegal.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data; byte/half data in low bits.
- p0_ack  out  1  one-cycle completion pulse.
- p0_err  out  1  qualifies p0_ack: request rejected.
- p0_rdata  out  DATA_W  read result, valid while p0_ack is high.
- p1_req, p1_we, p1_mode, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: identical to the port 0 set, for port 1.
- dm_addr  out  ADDR_W  memory address.
- dm_din  out  DATA_W  memory write data.
- dm_we  out  1  memory write enable.
- dm_mode  out  2  memory access mode.
- dm_dout  in  DATA_W  memory read data; registered by the memory on the access edge.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0, including dm_addr, dm_din, dm_we, dm_mode, both ack/err/rdata, and busy; last_grant=1, so port 0 wins first.
- FSM states: IDLE, ISSUE, CAPT, DONE. All outputs are registered.
- IDLE:
  - If no req is high, stay in IDLE with dm_we=0 and dm_mode=00.
  - Otherwise select a port:
    - only one req high: that port;
    - both high and PRIO_FIXED=1: port 0;
    - both high and PRIO_FIXED=0: the port that is not last_grant.
  - Latch the selected request and set last_grant to the selected port.
- Legality check, done in IDLE on the latched request:
  - mode=11 is illegal.
  - mode=10 with addr bit0=1 is misaligned.
  - mode=00 with addr[1:0]≠00 is misaligned.
  - Illegal or misaligned: go straight to DONE with err=1 and rdata=0. No memory access occurs; dm_we stays 0.
  - Legal: go to ISSUE.
- ISSUE (1 cycle):
  - dm_addr, dm_din, dm_mode take the latched values; dm_we is the latched we.
  - The memory performs the access on the closing edge of this cycle.
- CAPT (1 cycle):
  - dm_we←0 and dm_mode←00; dm_addr is held.
  - rdata register ← dm_dout for reads, 0 for writes.
- DONE (1 cycle):
  - The granted port sees ack=1; err as decided in IDLE; rdata = the captured value.
  - Requests are not sampled in DONE. Next state is IDLE.
  - A requester must drop req, or present its next request, in the cycle after ack.
- Latency:
  - Legal access: request seen in IDLE at cycle T, ack in cycle T+3.
  - Rejected request: ack in T+1.
  - Maximum throughput is one legal access per 4 cycles.
- The ungranted port's request stays pending; with round-robin it wins the next IDLE arbitration.
- Read data is passed through as the memory returns it. Byte and half reads arrive zero-extended; sign extension is the requester's job.
- Memory is never driven with mode 11; dm_mode is only ever 00, 01 or 10.
- Reset mid-transaction:
  - dm_we drops immediately, so a write aborted before the ISSUE edge never reaches memory.
  - No ack is issued for the aborted transaction; the requester must reissue it.
- A request that changes while pending but before it is granted is sampled as-is at the grant.

Test Plan:
- Single write, then read: p0 write word 0xDEADBEEF to addr 0x010 → dm_we=1 for exactly one cycle; p0_ack at T+3 with err=0. Then p0 read word at 0x010 → p0_rdata=0xDEADBEEF at T+3.
- Byte and half reads: after the word above, p1 byte read at addr 0x013 → rdata=0x000000DE. p1 half read at addr 0x012 → rdata=0x0000DEAD.
- Contention, round-robin: p0 and p1 both hold req from reset → grant order p0, p1, p0, p1. Acks are 4 cycles apart; busy stays high throughout.
- PRIO_FIXED=1: both ports request continuously → only p0 is acked; p1 is acked only after p0 drops req.
- Illegal and misaligned requests:
  - p0 mode=11 → p0_ack and p0_err=1 one cycle after grant; dm_we stays 0; a following read of that address still returns the old data.
  - p0 word read at addr 0x011 → err=1.
  - p0 half read at addr 0x013 → err=1.
- Reset during ISSUE of a write of 0x12345678 to 0x020: dm_we falls asynchronously; no ack; after reset a read of 0x020 returns the prior value; state=IDLE and all outputs are 0.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
// Bundle of both requester ports plus the data-memory side of the arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [1:0]        p0_mode;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_err;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [1:0]        p1_mode;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_err;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_din;
    logic              dm_we;
    logic [1:0]        dm_mode;
    logic [DATA_W-1:0] dm_dout;
    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_mode, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_mode, p1_addr, p1_wdata,
        input  dm_dout,
        output p0_ack, p0_err, p0_rdata,
        output p1_ack, p1_err, p1_rdata,
        output dm_addr, dm_din, dm_we, dm_mode, busy
    );

    modport master (
        output p0_req, p0_we, p0_mode, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_mode, p1_addr, p1_wdata,
        output dm_dout,
        input  p0_ack, p0_err, p0_rdata,
        input  p1_ack, p1_err, p1_rdata,
        input  dm_addr, dm_din, dm_we, dm_mode, busy
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter/sequencer for the byte-lane data memory: arbitrates, rejects
// illegal or misaligned requests, drives one memory access and returns an ack.
module dm_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int PRIO_FIXED = 0
) (
    input  logic             clk,
    input  logic             rst,
    dm_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              we_q;
    logic              busy_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic [DATA_W-1:0] dm_din_q;
    logic              dm_we_q;
    logic [1:0]        dm_mode_q;
    logic              p0_ack_q;
    logic              p0_err_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic              p1_ack_q;
    logic              p1_err_q;
    logic [DATA_W-1:0] p1_rdata_q;

    logic              any_req_d;
    logic              grant_d;
    logic              sel_we_d;
    logic [1:0]        sel_mode_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;
    logic              legal_d;

    // Port selection and legality of the request that would be latched now.
    always_comb begin
        any_req_d = bus.p0_req | bus.p1_req;
        case ({bus.p1_req, bus.p0_req})
            2'b10:   grant_d = 1'b1;
            2'b11:   grant_d = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant_q;
            default: grant_d = 1'b0;
        endcase
        if (grant_d) begin
            sel_we_d    = bus.p1_we;
            sel_mode_d  = bus.p1_mode;
            sel_addr_d  = bus.p1_addr;
            sel_wdata_d = bus.p1_wdata;
        end else begin
            sel_we_d    = bus.p0_we;
            sel_mode_d  = bus.p0_mode;
            sel_addr_d  = bus.p0_addr;
            sel_wdata_d = bus.p0_wdata;
        end
        case (sel_mode_d)
            2'b00:   legal_d = (sel_addr_d[1:0] == 2'b00);
            2'b01:   legal_d = 1'b1;
            2'b10:   legal_d = ~sel_addr_d[0];
            default: legal_d = 1'b0;
        endcase
    end

    // Sequencer FSM; every output is a register so the memory sees clean edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            dm_addr_q    <= {ADDR_W{1'b0}};
            dm_din_q     <= {DATA_W{1'b0}};
            dm_we_q      <= 1'b0;
            dm_mode_q    <= 2'b00;
            p0_ack_q     <= 1'b0;
            p0_err_q     <= 1'b0;
            p0_rdata_q   <= {DATA_W{1'b0}};
            p1_ack_q     <= 1'b0;
            p1_err_q     <= 1'b0;
            p1_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dm_we_q   <= 1'b0;
                    dm_mode_q <= 2'b00;
                    if (any_req_d) begin
                        last_grant_q <= grant_d;
                        grant_q      <= grant_d;
                        we_q         <= sel_we_d;
                        busy_q       <= 1'b1;
                        if (legal_d) begin
                            state_q   <= ST_ISSUE;
                            dm_addr_q <= sel_addr_d;
                            dm_din_q  <= sel_wdata_d;
                            dm_mode_q <= sel_mode_d;
                            dm_we_q   <= sel_we_d;
                        end else begin
                            // Rejected: answer immediately, the memory is never touched.
                            state_q    <= ST_DONE;
                            p0_ack_q   <= ~grant_d;
                            p0_err_q   <= ~grant_d;
                            p1_ack_q   <= grant_d;
                            p1_err_q   <= grant_d;
                            p0_rdata_q <= {DATA_W{1'b0}};
                            p1_rdata_q <= {DATA_W{1'b0}};
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_q   <= ST_CAPT;
                    dm_we_q   <= 1'b0;
                    dm_mode_q <= 2'b00;
                end
                ST_CAPT: begin
                    state_q    <= ST_DONE;
                    p0_ack_q   <= ~grant_q;
                    p1_ack_q   <= grant_q;
                    p0_err_q   <= 1'b0;
                    p1_err_q   <= 1'b0;
                    p0_rdata_q <= (~grant_q & ~we_q) ? bus.dm_dout : {DATA_W{1'b0}};
                    p1_rdata_q <= (grant_q & ~we_q) ? bus.dm_dout : {DATA_W{1'b0}};
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    p0_ack_q   <= 1'b0;
                    p0_err_q   <= 1'b0;
                    p0_rdata_q <= {DATA_W{1'b0}};
                    p1_ack_q   <= 1'b0;
                    p1_err_q   <= 1'b0;
                    p1_rdata_q <= {DATA_W{1'b0}};
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    dm_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dm_addr  = dm_addr_q;
    assign bus.dm_din   = dm_din_q;
    assign bus.dm_we    = dm_we_q;
    assign bus.dm_mode  = dm_mode_q;
    assign bus.busy     = busy_q;
    assign bus.p0_ack   = p0_ack_q;
    assign bus.p0_err   = p0_err_q;
    assign bus.p0_rdata = p0_rdata_q;
    assign bus.p1_ack   = p1_ack_q;
    assign bus.p1_err   = p1_err_q;
    assign bus.p1_rdata = p1_rdata_q;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: byte-lane memory model on the memory side, and a
// byte-array reference model that predicts every acknowledged result.
module tb_dm_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    dm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_fx ();

    dm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_FIXED(0)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    dm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_FIXED(1)) dut_fx (
        .clk(clk), .rst(rst), .bus(bus_fx));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int we_pulses = 0;
    int bad_mode = 0;
    int ack_port_q[$];
    int ack_cyc_q[$];
    int ack_busy_q[$];

    logic [7:0] mem [0:4095];
    logic [7:0] ref_mem [0:4095];

    logic [11:0] a0, a1, a2, a3;
    assign a0 = bus.dm_addr;
    assign a1 = bus.dm_addr + 12'd1;
    assign a2 = bus.dm_addr + 12'd2;
    assign a3 = bus.dm_addr + 12'd3;

    // Data memory: registered read on every edge, byte-lane writes, mode 11 read clears the word.
    always @(posedge clk) begin
        case (bus.dm_mode)
            2'b00: begin
                bus.dm_dout <= {mem[a3], mem[a2], mem[a1], mem[a0]};
                if (bus.dm_we) begin
                    mem[a0] <= bus.dm_din[7:0];
                    mem[a1] <= bus.dm_din[15:8];
                    mem[a2] <= bus.dm_din[23:16];
                    mem[a3] <= bus.dm_din[31:24];
                end
            end
            2'b01: begin
                bus.dm_dout <= {24'd0, mem[a0]};
                if (bus.dm_we) mem[a0] <= bus.dm_din[7:0];
            end
            2'b10: begin
                bus.dm_dout <= {16'd0, mem[a1], mem[a0]};
                if (bus.dm_we) begin
                    mem[a0] <= bus.dm_din[7:0];
                    mem[a1] <= bus.dm_din[15:8];
                end
            end
            default: begin
                bus.dm_dout <= 32'd0;
                if (!bus.dm_we) begin
                    mem[{a0[11:2], 2'b00}] <= 8'd0;
                    mem[{a0[11:2], 2'b01}] <= 8'd0;
                    mem[{a0[11:2], 2'b10}] <= 8'd0;
                    mem[{a0[11:2], 2'b11}] <= 8'd0;
                end
            end
        endcase
    end

    always @(posedge clk) bus_fx.dm_dout <= {20'd0, bus_fx.dm_addr};
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dm_we) we_pulses <= we_pulses + 1;
        if (bus.dm_mode == 2'b11 || bus_fx.dm_mode == 2'b11) bad_mode <= bad_mode + 1;
        if (bus.p0_ack) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); ack_busy_q.push_back(int'(bus.busy)); end
        if (bus.p1_ack) begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); ack_busy_q.push_back(int'(bus.busy)); end
    end

    function automatic int acc_size(input logic [1:0] mode);
        case (mode)
            2'b00:   return 4;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [1:0] mode, input logic [11:0] addr);
        int n;
        n = acc_size(mode);
        return (n != 0) && ((int'(addr) % n) == 0);
    endfunction

    function automatic logic [31:0] ref_read(input logic [11:0] addr, input logic [1:0] mode);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < acc_size(mode); i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        return v;
    endfunction

    task automatic ref_write(input logic [11:0] addr, input logic [1:0] mode, input logic [31:0] wd);
        for (int i = 0; i < acc_size(mode); i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
    endtask

    task automatic drive(input int port, input logic req, input logic we, input logic [1:0] mode,
                         input logic [11:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_mode = mode; bus.p0_addr = addr; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_mode = mode; bus.p1_addr = addr; bus.p1_wdata = wd;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends the ack cycle.
    task automatic do_txn(input int port, input logic we, input logic [1:0] mode, input logic [11:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err, output int lat);
        int  t0;
        bit  got;
        drive(port, 1'b1, we, mode, addr, wd);
        t0 = cyc; got = 1'b0; rd = 32'd0; err = 1'b0; lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? bus.p0_ack : bus.p1_ack) begin
                got = 1'b1;
                rd  = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
                err = (port == 0) ? bus.p0_err : bus.p1_err;
                lat = cyc - t0;
            end
        end
        n_vec++;
        if (!got) begin n_err++; $display("FAIL ack_timeout: port %0d got no ack in 40 cycles, expected an ack", port); end
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 2'b00, 12'h000, 32'd0);
    endtask

    task automatic test_reset();
        logic [115:0] outs;
        drive(0, 1'b0, 1'b0, 2'b00, 12'h000, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 12'h000, 32'd0);
        bus_fx.p0_req = 1'b0; bus_fx.p0_we = 1'b0; bus_fx.p0_mode = 2'b00; bus_fx.p0_addr = 12'h000; bus_fx.p0_wdata = 32'd0;
        bus_fx.p1_req = 1'b0; bus_fx.p1_we = 1'b0; bus_fx.p1_mode = 2'b00; bus_fx.p1_addr = 12'h000; bus_fx.p1_wdata = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {bus.p0_ack, bus.p0_err, bus.p0_rdata, bus.p1_ack, bus.p1_err, bus.p1_rdata,
                bus.dm_addr, bus.dm_din, bus.dm_we, bus.dm_mode, bus.busy};
        n_vec++;
        if (outs !== 116'd0) begin n_err++; $display("FAIL reset_outputs: got %h, expected all zero", outs); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int lat; int w0;
        w0 = we_pulses;
        do_txn(0, 1'b1, 2'b00, 12'h010, 32'hDEADBEEF, rd, err, lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency: got %0d, expected 3", lat); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL wr_err: got %b, expected 0", err); end
        n_vec++; if (we_pulses - w0 !== 1) begin n_err++; $display("FAIL wr_we_pulse: got %0d cycles, expected 1", we_pulses - w0); end
        do_txn(0, 1'b0, 2'b00, 12'h010, 32'd0, rd, err, lat);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_word: got %h, expected deadbeef", rd); end
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency: got %0d, expected 3", lat); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic err; int lat;
        do_txn(1, 1'b0, 2'b01, 12'h013, 32'd0, rd, err, lat);
        n_vec++; if (rd !== 32'h000000DE || err !== 1'b0) begin n_err++; $display("FAIL rd_byte: got %h err %b, expected 000000de err 0", rd, err); end
        do_txn(1, 1'b0, 2'b10, 12'h012, 32'd0, rd, err, lat);
        n_vec++; if (rd !== 32'h0000DEAD || err !== 1'b0) begin n_err++; $display("FAIL rd_half: got %h err %b, expected 0000dead err 0", rd, err); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic err; int lat; int w0;
        w0 = we_pulses;
        do_txn(0, 1'b0, 2'b11, 12'h010, 32'd0, rd, err, lat);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL ill_latency: got %0d, expected 1", lat); end
        n_vec++; if (err !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL ill_err: got err %b rdata %h, expected err 1 rdata 0", err, rd); end
        n_vec++; if (we_pulses !== w0) begin n_err++; $display("FAIL ill_no_write: got %0d we cycles, expected 0", we_pulses - w0); end
        do_txn(0, 1'b0, 2'b00, 12'h010, 32'd0, rd, err, lat);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL ill_old_data: got %h, expected deadbeef", rd); end
        do_txn(0, 1'b0, 2'b00, 12'h011, 32'd0, rd, err, lat);
        n_vec++; if (err !== 1'b1 || lat !== 1) begin n_err++; $display("FAIL mis_word: got err %b lat %0d, expected err 1 lat 1", err, lat); end
        do_txn(0, 1'b0, 2'b10, 12'h013, 32'd0, rd, err, lat);
        n_vec++; if (err !== 1'b1 || lat !== 1) begin n_err++; $display("FAIL mis_half: got err %b lat %0d, expected err 1 lat 1", err, lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r00, r01, r10, r11; logic e; int l;
        int exp_port[4];
        exp_port = '{0, 1, 0, 1};
        ack_port_q.delete(); ack_cyc_q.delete(); ack_busy_q.delete();
        rst = 1'b1;
        fork
            begin do_txn(0, 1'b0, 2'b00, 12'h010, 32'd0, r00, e, l); do_txn(0, 1'b0, 2'b01, 12'h010, 32'd0, r01, e, l); end
            begin do_txn(1, 1'b0, 2'b10, 12'h012, 32'd0, r10, e, l); do_txn(1, 1'b0, 2'b01, 12'h011, 32'd0, r11, e, l); end
            begin @(posedge clk); #1; rst = 1'b0; end
        join
        n_vec++;
        if (ack_port_q.size() !== 4) begin
            n_err++; $display("FAIL rr_ack_count: got %0d acks, expected 4", ack_port_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (ack_port_q[i] !== exp_port[i]) begin n_err++; $display("FAIL rr_order: ack %0d from port %0d, expected port %0d", i, ack_port_q[i], exp_port[i]); end
                n_vec++; if (ack_busy_q[i] !== 1) begin n_err++; $display("FAIL rr_busy: busy %0d at ack %0d, expected 1", ack_busy_q[i], i); end
                if (i > 0) begin
                    n_vec++; if (ack_cyc_q[i] - ack_cyc_q[i-1] !== 4) begin n_err++; $display("FAIL rr_spacing: %0d cycles between acks, expected 4", ack_cyc_q[i] - ack_cyc_q[i-1]); end
                end
            end
        end
        n_vec++; if (r10 !== 32'h0000DEAD || r11 !== 32'h000000BE) begin n_err++; $display("FAIL rr_p1_data: got %h %h, expected 0000dead 000000be", r10, r11); end
        n_vec++; if (r00 !== 32'hDEADBEEF || r01 !== 32'h000000EF) begin n_err++; $display("FAIL rr_p0_data: got %h %h, expected deadbeef 000000ef", r00, r01); end
    endtask

    task automatic test_fixed_prio();
        int n0; int n1; int wait_c; bit got;
        n0 = 0; n1 = 0;
        bus_fx.p0_req = 1'b1; bus_fx.p0_we = 1'b0; bus_fx.p0_mode = 2'b00; bus_fx.p0_addr = 12'h000;
        bus_fx.p1_req = 1'b1; bus_fx.p1_we = 1'b0; bus_fx.p1_mode = 2'b00; bus_fx.p1_addr = 12'h004;
        repeat (20) begin
            @(negedge clk);
            n0 = n0 + (bus_fx.p0_ack ? 1 : 0);
            n1 = n1 + (bus_fx.p1_ack ? 1 : 0);
        end
        n_vec++; if (n0 !== 5) begin n_err++; $display("FAIL fx_p0_acks: got %0d, expected 5", n0); end
        n_vec++; if (n1 !== 0) begin n_err++; $display("FAIL fx_p1_starved: got %0d acks, expected 0", n1); end
        @(posedge clk); #1;
        bus_fx.p0_req = 1'b0;
        got = 1'b0; wait_c = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (bus_fx.p1_ack) begin
                got = 1'b1; wait_c = i - 1;
                n_vec++; if (bus_fx.p1_rdata !== 32'h00000004) begin n_err++; $display("FAIL fx_p1_rdata: got %h, expected 00000004", bus_fx.p1_rdata); end
            end
        end
        n_vec++; if (!got || wait_c !== 3) begin n_err++; $display("FAIL fx_p1_after_drop: got ack %b after %0d cycles, expected ack after 3", got, wait_c); end
        @(posedge clk); #1;
        bus_fx.p1_req = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat; int w0; int acks; logic [115:0] outs;
        do_txn(0, 1'b1, 2'b00, 12'h020, 32'h0BADF00D, rd, err, lat);
        w0 = we_pulses;
        drive(0, 1'b1, 1'b1, 2'b00, 12'h020, 32'h12345678);
        @(posedge clk); #1;
        n_vec++; if (bus.dm_we !== 1'b1) begin n_err++; $display("FAIL mid_issue_we: got %b, expected 1", bus.dm_we); end
        rst = 1'b1;
        #1;
        n_vec++; if (bus.dm_we !== 1'b0) begin n_err++; $display("FAIL mid_async_we: got %b, expected 0", bus.dm_we); end
        drive(0, 1'b0, 1'b0, 2'b00, 12'h000, 32'd0);
        acks = 0;
        repeat (3) begin @(negedge clk); acks = acks + ((bus.p0_ack | bus.p1_ack) ? 1 : 0); end
        outs = {bus.p0_ack, bus.p0_err, bus.p0_rdata, bus.p1_ack, bus.p1_err, bus.p1_rdata,
                bus.dm_addr, bus.dm_din, bus.dm_we, bus.dm_mode, bus.busy};
        n_vec++; if (acks !== 0) begin n_err++; $display("FAIL mid_no_ack: got %0d acks, expected 0", acks); end
        n_vec++; if (outs !== 116'd0) begin n_err++; $display("FAIL mid_outputs: got %h, expected all zero", outs); end
        n_vec++; if (we_pulses !== w0) begin n_err++; $display("FAIL mid_no_write: got %0d we cycles, expected 0", we_pulses - w0); end
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn(0, 1'b0, 2'b00, 12'h020, 32'd0, rd, err, lat);
        n_vec++; if (rd !== 32'h0BADF00D) begin n_err++; $display("FAIL mid_prior_data: got %h, expected 0badf00d", rd); end
    endtask

    task automatic rand_port(input int port, input int n);
        logic we; logic [1:0] mode; logic [11:0] addr; logic [31:0] wd; logic [31:0] rd; logic [31:0] exp_rd;
        logic err; int lat; bit legal;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            we    = 1'($urandom_range(0, 1));
            mode  = 2'($urandom_range(0, 3));
            addr  = 12'h100 + 12'($urandom_range(0, 31));
            wd    = $urandom();
            legal = ref_legal(mode, addr);
            do_txn(port, we, mode, addr, wd, rd, err, lat);
            exp_rd = (legal && !we) ? ref_read(addr, mode) : 32'd0;
            if (legal && we) ref_write(addr, mode, wd);
            n_vec++;
            if (err !== !legal || rd !== exp_rd) begin
                n_err++; $display("FAIL rand_result: port %0d we %b mode %b addr %h got err %b rdata %h, expected err %b rdata %h",
                                  port, we, mode, addr, err, rd, !legal, exp_rd);
            end
            n_vec++;
            if (lat < (legal ? 3 : 1) || lat > (legal ? 8 : 6)) begin
                n_err++; $display("FAIL rand_latency: port %0d legal %b got %0d cycles, expected %0d..%0d", port, legal, lat, legal ? 3 : 1, legal ? 8 : 6);
            end
        end
    endtask

    task automatic test_random();
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        n_vec++; if (bad_mode !== 0) begin n_err++; $display("FAIL dm_mode_11: seen in %0d cycles, expected 0", bad_mode); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin mem[i] = 8'd0; ref_mem[i] = 8'd0; end
        test_reset();
        test_write_read();
        test_byte_half();
        test_illegal();
        test_back_to_back();
        test_fixed_prio();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
